dht_responder: RTL and testbench



---
 rtl/dht_pkg.sv | 42 ++++
 rtl/dht_responder_sync_2ff.sv | 29 ++
 rtl/dht_responder.sv | 247 ++++++++++++++++++++++++
 tb/tb_dht_responder.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dht_pkg.sv
// Shared DHT11 protocol definitions: FSM states, tick timing constants
// (10 us units, also used by the host controller) and the checksum helper.
package dht_pkg;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_START_LOW = 4'd1,
        ST_TURN      = 4'd2,
        ST_RESP_LOW  = 4'd3,
        ST_RESP_HIGH = 4'd4,
        ST_BIT_LOW   = 4'd5,
        ST_BIT_HIGH  = 4'd6,
        ST_END_LOW   = 4'd7,
        ST_WAIT_HIGH = 4'd8
    } dht_state_e;

    localparam int C_START_TICKS   = 1800;
    localparam int C_TURN_TICKS    = 3;
    localparam int C_RESP_TICKS    = 8;
    localparam int C_BIT_LOW_TICKS = 5;
    localparam int C_ZERO_TICKS    = 3;
    localparam int C_ONE_TICKS     = 7;
    localparam int C_FRAME_BITS    = 40;

    // Tick counter width; must hold the start-pulse threshold (1800 < 2048).
    localparam int C_CNT_W = 11;

    // Frame checksum: 8-bit wrapping sum of the four payload bytes,
    // optionally inverted to exercise the host's error path.
    function automatic logic [7:0] dht_checksum(
        input logic [7:0] humid_int,
        input logic [7:0] humid_dec,
        input logic [7:0] temp_int,
        input logic [7:0] temp_dec,
        input logic       corrupt
    );
        logic [7:0] sum;
        sum = humid_int + humid_dec + temp_int + temp_dec;
        return corrupt ? ~sum : sum;
    endfunction

endpackage

// File: rtl/dht_responder_sync_2ff.sv
// Generic two-flop synchronizer for an asynchronous level input.
// Reset value is a parameter; the DHT bus idles high, so the default is 1.
module sync_2ff #(
    parameter int   WIDTH   = 1,
    parameter logic RST_VAL = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_r;
    logic [WIDTH-1:0] sync_r;

    // Two-stage capture of the asynchronous input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_r <= {WIDTH{RST_VAL}};
            sync_r <= {WIDTH{RST_VAL}};
        end else begin
            meta_r <= d;
            sync_r <= meta_r;
        end
    end

    assign q = sync_r;

endmodule

// File: rtl/dht_responder.sv
// DHT11 sensor emulator: waits for a host start pulse on the open-drain bus,
// then answers with the response preamble and a 40-bit frame
// (humidity int/dec, temperature int/dec, checksum), MSB first.
module dht_responder
    import dht_pkg::*;
#(
    parameter int P_START_TICKS   = C_START_TICKS,
    parameter int P_TURN_TICKS    = C_TURN_TICKS,
    parameter int P_RESP_TICKS    = C_RESP_TICKS,
    parameter int P_BIT_LOW_TICKS = C_BIT_LOW_TICKS,
    parameter int P_ZERO_TICKS    = C_ZERO_TICKS,
    parameter int P_ONE_TICKS     = C_ONE_TICKS
) (
    input  logic       iClk,
    input  logic       iRst_n,
    input  logic       iTick_10us,
    input  logic       iDHT,
    output logic       oDHT_Oe,
    input  logic       iEnable,
    input  logic [7:0] iHumid_Int,
    input  logic [7:0] iHumid_Dec,
    input  logic [7:0] iTemp_Int,
    input  logic [7:0] iTemp_Dec,
    input  logic       iCorrupt_Cs,
    output logic       oBusy,
    output logic       oDone
);

    // Counter values are "ticks seen so far"; a timed phase ends on the tick
    // that would bring the count to N, i.e. while the counter holds N-1.
    localparam logic [C_CNT_W-1:0] L_ZERO          = {C_CNT_W{1'b0}};
    localparam logic [C_CNT_W-1:0] L_ONE           = {{(C_CNT_W-1){1'b0}}, 1'b1};
    localparam logic [C_CNT_W-1:0] L_START         = C_CNT_W'(P_START_TICKS);
    localparam logic [C_CNT_W-1:0] L_TURN_LAST     = C_CNT_W'(P_TURN_TICKS - 1);
    localparam logic [C_CNT_W-1:0] L_RESP_LAST     = C_CNT_W'(P_RESP_TICKS - 1);
    localparam logic [C_CNT_W-1:0] L_BIT_LOW_LAST  = C_CNT_W'(P_BIT_LOW_TICKS - 1);
    localparam logic [C_CNT_W-1:0] L_ZERO_LAST     = C_CNT_W'(P_ZERO_TICKS - 1);
    localparam logic [C_CNT_W-1:0] L_ONE_LAST      = C_CNT_W'(P_ONE_TICKS - 1);
    localparam logic [5:0]         L_LAST_BIT      = 6'(C_FRAME_BITS - 1);

    logic                    bus_s;
    dht_state_e              state_r;
    dht_state_e              state_nxt_s;
    logic [C_CNT_W-1:0]      cnt_r;
    logic [C_CNT_W-1:0]      cnt_nxt_s;
    logic [5:0]              bit_r;
    logic [5:0]              bit_nxt_s;
    logic [C_FRAME_BITS-1:0] shift_r;
    logic [C_FRAME_BITS-1:0] shift_nxt_s;
    logic [C_CNT_W-1:0]      phase_last_s;
    logic                    phase_end_s;
    logic                    oe_r;
    logic                    busy_r;
    logic                    done_r;
    logic                    oe_nxt_s;
    logic                    busy_nxt_s;
    logic                    done_nxt_s;

    sync_2ff #(
        .WIDTH   (1),
        .RST_VAL (1'b1)
    ) u_sync (
        .clk   (iClk),
        .rst_n (iRst_n),
        .d     (iDHT),
        .q     (bus_s)
    );

    // Last counter value of the current timed phase; BIT_HIGH depends on the bit.
    always_comb begin
        phase_last_s = L_ZERO;
        case (state_r)
            ST_TURN:      phase_last_s = L_TURN_LAST;
            ST_RESP_LOW:  phase_last_s = L_RESP_LAST;
            ST_RESP_HIGH: phase_last_s = L_RESP_LAST;
            ST_BIT_LOW:   phase_last_s = L_BIT_LOW_LAST;
            ST_END_LOW:   phase_last_s = L_BIT_LOW_LAST;
            ST_BIT_HIGH:  phase_last_s = shift_r[C_FRAME_BITS-1] ? L_ONE_LAST : L_ZERO_LAST;
            default:      phase_last_s = L_ZERO;
        endcase
    end

    assign phase_end_s = iTick_10us && (cnt_r == phase_last_s);

    // Next-state, counter, bit index and shift register logic.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        bit_nxt_s   = bit_r;
        shift_nxt_s = shift_r;

        // Shared tick counting for all timed (bus-ignoring) phases.
        case (state_r)
            ST_TURN, ST_RESP_LOW, ST_RESP_HIGH, ST_BIT_LOW, ST_BIT_HIGH, ST_END_LOW: begin
                if (phase_end_s) begin
                    cnt_nxt_s = L_ZERO;
                end else if (iTick_10us) begin
                    cnt_nxt_s = cnt_r + L_ONE;
                end else begin
                    cnt_nxt_s = cnt_r;
                end
            end
            default: begin
                cnt_nxt_s = cnt_r;
            end
        endcase

        case (state_r)
            ST_IDLE: begin
                if (!bus_s && iEnable) begin
                    state_nxt_s = ST_START_LOW;
                    cnt_nxt_s   = L_ZERO;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_START_LOW: begin
                if (bus_s) begin
                    cnt_nxt_s = L_ZERO;
                    if (cnt_r >= L_START) begin
                        // Host released after a valid start: snapshot the payload.
                        state_nxt_s = ST_TURN;
                        bit_nxt_s   = 6'd0;
                        shift_nxt_s = {iHumid_Int, iHumid_Dec, iTemp_Int, iTemp_Dec,
                                       dht_checksum(iHumid_Int, iHumid_Dec,
                                                    iTemp_Int, iTemp_Dec, iCorrupt_Cs)};
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end else if (iTick_10us && (cnt_r < L_START)) begin
                    cnt_nxt_s = cnt_r + L_ONE;
                end else begin
                    cnt_nxt_s = cnt_r;
                end
            end
            ST_TURN: begin
                if (phase_end_s) begin
                    state_nxt_s = ST_RESP_LOW;
                end else begin
                    state_nxt_s = ST_TURN;
                end
            end
            ST_RESP_LOW: begin
                if (phase_end_s) begin
                    state_nxt_s = ST_RESP_HIGH;
                end else begin
                    state_nxt_s = ST_RESP_LOW;
                end
            end
            ST_RESP_HIGH: begin
                if (phase_end_s) begin
                    state_nxt_s = ST_BIT_LOW;
                end else begin
                    state_nxt_s = ST_RESP_HIGH;
                end
            end
            ST_BIT_LOW: begin
                if (phase_end_s) begin
                    state_nxt_s = ST_BIT_HIGH;
                end else begin
                    state_nxt_s = ST_BIT_LOW;
                end
            end
            ST_BIT_HIGH: begin
                if (phase_end_s) begin
                    if (bit_r == L_LAST_BIT) begin
                        state_nxt_s = ST_END_LOW;
                    end else begin
                        state_nxt_s = ST_BIT_LOW;
                        bit_nxt_s   = bit_r + 6'd1;
                        shift_nxt_s = {shift_r[C_FRAME_BITS-2:0], 1'b0};
                    end
                end else begin
                    state_nxt_s = ST_BIT_HIGH;
                end
            end
            ST_END_LOW: begin
                if (phase_end_s) begin
                    state_nxt_s = ST_WAIT_HIGH;
                end else begin
                    state_nxt_s = ST_END_LOW;
                end
            end
            ST_WAIT_HIGH: begin
                // Bus must be seen high again before a new start can arm.
                if (bus_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_WAIT_HIGH;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                cnt_nxt_s   = L_ZERO;
            end
        endcase
    end

    // Output values for the next cycle, derived from the next state so the
    // registered outputs change on the same edge as the state.
    always_comb begin
        oe_nxt_s   = 1'b0;
        busy_nxt_s = 1'b0;
        done_nxt_s = 1'b0;
        case (state_nxt_s)
            ST_RESP_LOW, ST_BIT_LOW, ST_END_LOW: oe_nxt_s = 1'b1;
            default:                             oe_nxt_s = 1'b0;
        endcase
        case (state_nxt_s)
            ST_TURN, ST_RESP_LOW, ST_RESP_HIGH, ST_BIT_LOW, ST_BIT_HIGH, ST_END_LOW:
                busy_nxt_s = 1'b1;
            default:
                busy_nxt_s = 1'b0;
        endcase
        if ((state_r == ST_END_LOW) && (state_nxt_s == ST_WAIT_HIGH)) begin
            done_nxt_s = 1'b1;
        end else begin
            done_nxt_s = 1'b0;
        end
    end

    // State, datapath and registered outputs; reset releases the bus at once.
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            state_r <= ST_IDLE;
            cnt_r   <= L_ZERO;
            bit_r   <= 6'd0;
            shift_r <= {C_FRAME_BITS{1'b0}};
            oe_r    <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
            bit_r   <= bit_nxt_s;
            shift_r <= shift_nxt_s;
            oe_r    <= oe_nxt_s;
            busy_r  <= busy_nxt_s;
            done_r  <= done_nxt_s;
        end
    end

    assign oDHT_Oe = oe_r;
    assign oBusy   = busy_r;
    assign oDone   = done_r;

endmodule

// File: tb/tb_dht_responder.sv
// Directed bench for dht_responder: plays the DHT host on an open-drain bus
// model, decodes the responder's frame by measuring phase widths in ticks.
module tb_dht_responder;
    import dht_pkg::*;

    logic       iClk = 1'b0;
    logic       iRst_n;
    logic       iTick_10us;
    logic       iDHT;
    logic       oDHT_Oe;
    logic       iEnable;
    logic [7:0] iHumid_Int;
    logic [7:0] iHumid_Dec;
    logic [7:0] iTemp_Int;
    logic [7:0] iTemp_Dec;
    logic       iCorrupt_Cs;
    logic       oBusy;
    logic       oDone;

    logic host_low = 1'b0;
    int   errors   = 0;
    int   checks   = 0;
    int   done_cnt = 0;

    dht_responder dut (
        .iClk        (iClk),
        .iRst_n      (iRst_n),
        .iTick_10us  (iTick_10us),
        .iDHT        (iDHT),
        .oDHT_Oe     (oDHT_Oe),
        .iEnable     (iEnable),
        .iHumid_Int  (iHumid_Int),
        .iHumid_Dec  (iHumid_Dec),
        .iTemp_Int   (iTemp_Int),
        .iTemp_Dec   (iTemp_Dec),
        .iCorrupt_Cs (iCorrupt_Cs),
        .oBusy       (oBusy),
        .oDone       (oDone)
    );

    // Open-drain bus: low if either end pulls, pulled up otherwise.
    assign iDHT = ~(host_low | oDHT_Oe);

    always #5 iClk = ~iClk;

    // Tick strobe every 4 clocks, changed on the falling edge.
    initial begin
        int div;
        div = 0;
        iTick_10us = 1'b0;
        forever begin
            @(negedge iClk);
            iTick_10us = (div == 0);
            div = (div + 1) % 4;
        end
    end

    // Count completed-frame pulses.
    always @(negedge iClk) begin
        if (oDone === 1'b1) done_cnt++;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Sample point: just after the falling edge, pairing this cycle's tick with oDHT_Oe.
    task automatic step();
        @(negedge iClk);
        #1;
    endtask

    // Count ticks while oDHT_Oe stays at level, starting at the current sample.
    task automatic measure(input logic level, output int ticks, output bit ok);
        int cyc;
        ticks = 0;
        ok    = 1'b1;
        cyc   = 0;
        while (oDHT_Oe === level) begin
            if (iTick_10us) ticks++;
            step();
            cyc++;
            if (cyc > 4000) begin
                ok = 1'b0;
                break;
            end
        end
    endtask

    // Host start pulse: pull low on a tick, hold for n further ticks, release.
    task automatic host_start(input int n);
        int cnt;
        int guard;
        guard = 0;
        step();
        while (!iTick_10us && guard < 8) begin
            step();
            guard++;
        end
        host_low = 1'b1;
        cnt = 0;
        while (cnt < n) begin
            step();
            if (iTick_10us) cnt++;
        end
        host_low = 1'b0;
        step();
    endtask

    // Watch n ticks and count any bus drive or busy indication.
    task automatic watch_quiet(input string tag, input int n);
        int tk;
        int oe_hits;
        int busy_hits;
        tk = 0;
        oe_hits = 0;
        busy_hits = 0;
        while (tk < n) begin
            step();
            if (iTick_10us) tk++;
            if (oDHT_Oe !== 1'b0) oe_hits++;
            if (oBusy !== 1'b0) busy_hits++;
        end
        check({tag, ".oe_quiet"}, 64'(oe_hits), 64'd0);
        check({tag, ".busy_quiet"}, 64'(busy_hits), 64'd0);
        check({tag, ".idle"}, 64'(dut.state_r), 64'(ST_IDLE));
    endtask

    // Decode a response; stop_at < 40 returns at the start of that bit's low phase.
    task automatic receive_frame(input logic [39:0] exp, input string tag, input int stop_at);
        int t;
        int lo;
        int hi;
        int bad_lo;
        int bad_hi;
        int done0;
        bit ok;
        logic [39:0] got;
        bad_lo = 0;
        bad_hi = 0;
        got    = 40'd0;
        done0  = done_cnt;
        measure(1'b0, t, ok);
        if (!ok) begin check({tag, ".timeout_turn"}, 64'd0, 64'd1); return; end
        check({tag, ".turn_ticks"}, 64'(t), 64'd3);
        check({tag, ".busy_in_frame"}, 64'(oBusy), 64'd1);
        measure(1'b1, t, ok);
        if (!ok) begin check({tag, ".timeout_resp_low"}, 64'd0, 64'd1); return; end
        check({tag, ".resp_low_ticks"}, 64'(t), 64'd8);
        measure(1'b0, t, ok);
        if (!ok) begin check({tag, ".timeout_resp_high"}, 64'd0, 64'd1); return; end
        check({tag, ".resp_high_ticks"}, 64'(t), 64'd8);
        for (int i = 0; i < 40; i++) begin
            if (i == stop_at) return;
            measure(1'b1, lo, ok);
            if (!ok) begin check({tag, ".timeout_bit_low"}, 64'd0, 64'd1); return; end
            measure(1'b0, hi, ok);
            if (!ok) begin check({tag, ".timeout_bit_high"}, 64'd0, 64'd1); return; end
            if (lo != 5) bad_lo++;
            if (hi != 3 && hi != 7) bad_hi++;
            got = {got[38:0], (hi > 5)};
        end
        measure(1'b1, t, ok);
        if (!ok) begin check({tag, ".timeout_end"}, 64'd0, 64'd1); return; end
        check({tag, ".end_low_ticks"}, 64'(t), 64'd5);
        check({tag, ".done_at_end"}, 64'(oDone), 64'd1);
        check({tag, ".busy_cleared"}, 64'(oBusy), 64'd0);
        check({tag, ".bit_low_width_errs"}, 64'(bad_lo), 64'd0);
        check({tag, ".bit_high_width_errs"}, 64'(bad_hi), 64'd0);
        check({tag, ".data"}, 64'(got[39:8]), 64'(exp[39:8]));
        check({tag, ".checksum"}, 64'(got[7:0]), 64'(exp[7:0]));
        step();
        step();
        check({tag, ".done_pulses"}, 64'(done_cnt - done0), 64'd1);
    endtask

    initial begin
        iRst_n      = 1'b0;
        iEnable     = 1'b0;
        iCorrupt_Cs = 1'b0;
        iHumid_Int  = 8'h00;
        iHumid_Dec  = 8'h00;
        iTemp_Int   = 8'h00;
        iTemp_Dec   = 8'h00;
        repeat (3) step();
        check("reset.oe", 64'(oDHT_Oe), 64'd0);
        check("reset.busy", 64'(oBusy), 64'd0);
        check("reset.done", 64'(oDone), 64'd0);
        check("reset.state", 64'(dut.state_r), 64'(ST_IDLE));
        iRst_n = 1'b1;
        repeat (3) step();

        // T1: nominal frame; payload and enable change after the latch.
        iEnable    = 1'b1;
        iHumid_Int = 8'h37;
        iHumid_Dec = 8'h00;
        iTemp_Int  = 8'h19;
        iTemp_Dec  = 8'h05;
        host_start(1800);
        step();
        step();
        iHumid_Int = 8'hAA;
        iHumid_Dec = 8'hBB;
        iTemp_Int  = 8'hCC;
        iTemp_Dec  = 8'hDD;
        iEnable    = 1'b0;
        receive_frame(40'h37_00_19_05_55, "t1", 40);
        iEnable = 1'b1;

        // T2: checksum wraps to zero.
        iHumid_Int = 8'hFF;
        iHumid_Dec = 8'hFF;
        iTemp_Int  = 8'h01;
        iTemp_Dec  = 8'h01;
        host_start(1800);
        receive_frame(40'hFF_FF_01_01_00, "t2", 40);

        // T3: 10 ms start is rejected.
        host_start(1000);
        watch_quiet("t3", 50);

        // T4: corrupted checksum, data bytes untouched.
        iCorrupt_Cs = 1'b1;
        iHumid_Int  = 8'h37;
        iHumid_Dec  = 8'h00;
        iTemp_Int   = 8'h19;
        iTemp_Dec   = 8'h05;
        host_start(1800);
        receive_frame(40'h37_00_19_05_AA, "t4", 40);
        iCorrupt_Cs = 1'b0;

        // T5: reset during bit 20 releases the bus at once; next frame is clean.
        iHumid_Int = 8'h12;
        iHumid_Dec = 8'h34;
        iTemp_Int  = 8'h56;
        iTemp_Dec  = 8'h78;
        host_start(1800);
        receive_frame(40'h12_34_56_78_14, "t5a", 20);
        check("t5.driving_before_reset", 64'(oDHT_Oe), 64'd1);
        iRst_n = 1'b0;
        #1;
        check("t5.oe_async_release", 64'(oDHT_Oe), 64'd0);
        check("t5.busy_async_clear", 64'(oBusy), 64'd0);
        step();
        iRst_n = 1'b1;
        repeat (3) step();
        check("t5.state_after_reset", 64'(dut.state_r), 64'(ST_IDLE));
        host_start(1800);
        receive_frame(40'h12_34_56_78_14, "t5b", 40);

        // T6: start pulse while disabled gets no response.
        iEnable = 1'b0;
        host_start(1800);
        watch_quiet("t6", 50);

        check("total_done_pulses", 64'(done_cnt), 64'd4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
